seq_signed_divider: RTL
=======================

Name: seq_signed_divider

Overview:
- Sequential signed divider: inverse operation of the sequential signed multiplier, using the same operand conventions.
- Takes WIDTH-bit two's-complement dividend and divisor from the switches and produces quotient and remainder as sign flag plus magnitude, ready for binary-to-BCD conversion and the seven-segment path.
- Algorithm: restoring division on magnitudes, one quotient bit per clock, with a start/busy/done handshake driven by the control unit.

Parameters:
WIDTH, 8, operand width in bits (two's complement in, unsigned magnitude out)

Ports:
clk  input  1  divided system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse from push-button detector/control unit; requests a new division
inDividend  input  WIDTH  signed dividend
inDivisor  input  WIDTH  signed divisor
busy  output  1  high while iterating
done  output  1  high while results valid; held until next accepted start
divByZero  output  1  high with done when divisor was zero
quotientMag  output  WIDTH  quotient magnitude, unsigned
remainderMag  output  WIDTH  remainder magnitude, unsigned
negativeQuotientFlag  output  1  quotient sign
negativeRemainderFlag  output  1  remainder sign (follows dividend)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal registers 0. Applies mid-operation as well: the division in progress is abandoned and no done is produced.
- States: IDLE, ITER, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE. On that edge:
    - latch |inDividend| and |inDivisor| as WIDTH-bit unsigned; -2^(WIDTH-1) gives 2^(WIDTH-1).
    - latch sign bits.
    - clear done and divByZero.
  - If the divisor magnitude is 0: go to DONE. done=1 and divByZero=1 after that same edge. quotientMag = all ones, remainderMag = |dividend|, both neg flags 0.
  - Otherwise: go to ITER. Partial remainder R (WIDTH+1 bits) = 0, Q = |dividend|, counter = WIDTH, busy=1.
  - start while in ITER is ignored; the operation is unaffected.
- ITER, each edge:
  - shift {R,Q} left by one.
  - T = R - {0,|divisor|}.
  - if T >= 0: R = T, Q[0] = 1; else Q[0] = 0.
  - decrement counter.
  - On the WIDTH-th ITER edge: go to DONE, busy=0, done=1. quotientMag = Q, remainderMag = R[WIDTH-1:0].
- Latency: start accepted at edge k gives busy high after edges k..k+WIDTH-1 and done=1 after edge k+WIDTH. Divide-by-zero gives done after edge k.
- Signs (truncating division):
  - negativeQuotientFlag = signDividend XOR signDivisor, forced 0 when quotientMag = 0.
  - negativeRemainderFlag = signDividend, forced 0 when remainderMag = 0.
  - No negative zero is ever reported.
- Range: quotient magnitude is at most 2^(WIDTH-1) (most negative / -1), which fits unsigned WIDTH bits; no overflow flag.
- DONE holds all outputs stable while inputs change; only a new start or reset alters them.
- Operand inputs are sampled only on the accepting edge; changes during ITER have no effect.
- busy and done are never simultaneously 1.

Test Plan:
- Positive case: 100 / 7, start pulse -> busy for 8 cycles; then done=1, quotientMag=14, remainderMag=2, both neg flags 0.
- Negative dividend: -100 / 7 -> quotientMag=14 with negativeQuotientFlag=1; remainderMag=2 with negativeRemainderFlag=1. Also -3 / 7 -> quotientMag=0 with flag 0, remainderMag=3 with flag 1.
- Extremes: -128 / -1 -> quotientMag=128, flags 0, remainderMag=0. -128 / 127 -> quotientMag=1 neg, remainderMag=1 neg.
- Divide by zero: 5 / 0 -> done=1 and divByZero=1 one edge after start, busy never high, quotientMag=255, remainderMag=5.
- Handshake: start re-pulsed at ITER cycle 3 with new operands -> ignored, original result at cycle 8. Start in DONE -> done drops next edge and a new division runs.
- Reset mid-operation: drive rst=0 asynchronously at ITER cycle 4 -> all outputs 0 immediately, state IDLE. After release, done stays 0 until a new start.

Source files
------------

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, reporting quotient and remainder as sign flag plus magnitude.
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inDividend,
  input  logic [WIDTH-1:0] inDivisor,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] quotientMag,
  output logic [WIDTH-1:0] remainderMag,
  output logic             negativeQuotientFlag,
  output logic             negativeRemainderFlag
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_dvd_q;
  logic             sgn_dvs_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shift_r;
  logic [WIDTH:0]   trial_r;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // The settled remainder is always below the divisor (at most 2^(WIDTH-1)), so it is
  // stored in WIDTH bits; only the shifted trial value needs the extra bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvd_mag = inDividend[WIDTH-1] ? -inDividend : inDividend;
    dvs_mag = inDivisor[WIDTH-1]  ? -inDivisor  : inDivisor;
    shift_r = {rem_q, quo_q[WIDTH-1]};
    trial_r = shift_r - {1'b0, dvs_q};
    if (!trial_r[WIDTH]) begin
      rem_d = trial_r[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shift_r[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge
  // values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q               <= IDLE;
      rem_q                 <= '0;
      quo_q                 <= '0;
      dvs_q                 <= '0;
      cnt_q                 <= '0;
      sgn_dvd_q             <= 1'b0;
      sgn_dvs_q             <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      divByZero             <= 1'b0;
      quotientMag           <= '0;
      remainderMag          <= '0;
      negativeQuotientFlag  <= 1'b0;
      negativeRemainderFlag <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sgn_dvd_q             <= inDividend[WIDTH-1];
            sgn_dvs_q             <= inDivisor[WIDTH-1];
            dvs_q                 <= dvs_mag;
            negativeQuotientFlag  <= 1'b0;
            negativeRemainderFlag <= 1'b0;
            if (dvs_mag == '0) begin
              state_q      <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              divByZero    <= 1'b1;
              quotientMag  <= '1;
              remainderMag <= dvd_mag;
            end else begin
              state_q      <= ITER;
              busy         <= 1'b1;
              done         <= 1'b0;
              divByZero    <= 1'b0;
              quotientMag  <= '0;
              remainderMag <= '0;
              rem_q        <= '0;
              quo_q        <= dvd_mag;
              cnt_q        <= CNT_W'(WIDTH);
            end
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q               <= DONE;
            busy                  <= 1'b0;
            done                  <= 1'b1;
            quotientMag           <= quo_d;
            remainderMag          <= rem_d;
            // Truncating division: a zero magnitude never carries a sign.
            negativeQuotientFlag  <= (sgn_dvd_q ^ sgn_dvs_q) && (quo_d != '0);
            negativeRemainderFlag <= sgn_dvd_q && (rem_d != '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
